// File: rtl/id_ex_alu_issue_if.sv
// ID->EX issue-stage bus: ID-side valid/ready with decoded-stage inputs, EX-side valid/ready with ALU payload.
// Optional `illegal` signal is present only when ID_EX_ILLEGAL_DET_EN is defined.
interface id_ex_alu_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        ex_valid;
    logic        ex_ready;
    logic [3:0]  alucon;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        we;
`ifdef ID_EX_ILLEGAL_DET_EN
    logic        illegal;
`endif

    // slave: the issue stage itself; master: the surrounding ID/EX environment
    modport slave (
        input  in_valid, instr, pc, rs1_data, rs2_data, ex_ready,
`ifdef ID_EX_ILLEGAL_DET_EN
        output illegal,
`endif
        output in_ready, ex_valid, alucon, op1, op2, rd, we
    );

    modport master (
        output in_valid, instr, pc, rs1_data, rs2_data, ex_ready,
`ifdef ID_EX_ILLEGAL_DET_EN
        input  illegal,
`endif
        input  in_ready, ex_valid, alucon, op1, op2, rd, we
    );
endinterface

// File: rtl/id_ex_alu_issue.sv
// RV32I decode-to-execute issue stage: ALU op/operand decode into a registered output plus one-entry skid buffer.
// Optional illegal-instruction detection enabled by defining ID_EX_ILLEGAL_DET_EN.
module id_ex_alu_issue (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    id_ex_alu_issue_if.slave  bus
);

    typedef struct packed {
        logic [3:0]  alucon;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        we;
`ifdef ID_EX_ILLEGAL_DET_EN
        logic        illegal;
`endif
    } payload_t;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        f7b5;
    logic [4:0]  rd_f;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;

    assign opcode = bus.instr[6:0];
    assign f3     = bus.instr[14:12];
    assign f7     = bus.instr[31:25];
    assign f7b5   = bus.instr[30];
    assign rd_f   = bus.instr[11:7];
    assign imm_i  = {{20{bus.instr[31]}}, bus.instr[31:20]};
    assign imm_s  = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
    assign imm_u  = {bus.instr[31:12], 12'b0};

    payload_t dec;
    logic     bad;
    logic     wr;

    always_comb begin
        dec = '0;
        bad = 1'b0;
        wr  = 1'b0;
        case (opcode)
            7'b0110011: begin
                dec.alucon = {f7b5 & (f3 == 3'b000 || f3 == 3'b101), f3};
                dec.op1    = bus.rs1_data;
                dec.op2    = bus.rs2_data;
                wr         = 1'b1;
                bad        = !(f7 == 7'h00 || f7 == 7'h20) ||
                             (f7 == 7'h20 && !(f3 == 3'b000 || f3 == 3'b101));
            end
            7'b0010011: begin
                dec.alucon = {(f3 == 3'b101) & f7b5, f3};
                dec.op1    = bus.rs1_data;
                dec.op2    = (f3 == 3'b001 || f3 == 3'b101) ? {27'b0, bus.instr[24:20]} : imm_i;
                wr         = 1'b1;
                bad        = (f3 == 3'b001 && f7 != 7'h00) ||
                             (f3 == 3'b101 && !(f7 == 7'h00 || f7 == 7'h20));
            end
            7'b0000011: begin
                dec.op1 = bus.rs1_data;
                dec.op2 = imm_i;
                wr      = 1'b1;
            end
            7'b0100011: begin
                dec.op1 = bus.rs1_data;
                dec.op2 = imm_s;
            end
            7'b0110111: begin
                dec.op2 = imm_u;
                wr      = 1'b1;
            end
            7'b0010111: begin
                dec.op1 = bus.pc;
                dec.op2 = imm_u;
                wr      = 1'b1;
            end
            7'b1101111, 7'b1100111: begin
                dec.op1 = bus.pc;
                dec.op2 = 32'd4;
                wr      = 1'b1;
            end
            7'b1100011: begin
                dec.op1 = bus.rs1_data;
                dec.op2 = bus.rs2_data;
                case (f3)
                    3'b000, 3'b001: dec.alucon = 4'd8;
                    3'b100, 3'b101: dec.alucon = 4'd2;
                    3'b110, 3'b111: dec.alucon = 4'd3;
                    default:        bad = 1'b1;
                endcase
            end
            default: bad = 1'b1;
        endcase
        // x0 destination never writes, and rd is only reported for writes
        dec.we = wr & (rd_f != 5'd0);
        dec.rd = dec.we ? rd_f : 5'd0;
`ifdef ID_EX_ILLEGAL_DET_EN
        if (bad) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
`endif
    end

    logic unused_bits;
`ifdef ID_EX_ILLEGAL_DET_EN
    assign unused_bits = ^bus.instr[19:15];
`else
    assign unused_bits = ^{bus.instr[19:15], bad};
`endif

    payload_t out_q, out_n, skid_q, skid_n;
    logic     out_valid, out_valid_n;
    logic     skid_valid, skid_valid_n;
    logic     in_ready_q;
    logic     accept, consume;

    assign accept  = bus.in_valid & in_ready_q;
    assign consume = out_valid & bus.ex_ready;

    always_comb begin
        out_n        = out_q;
        out_valid_n  = out_valid;
        skid_n       = skid_q;
        skid_valid_n = skid_valid;
        if (consume && skid_valid) begin
            out_n        = skid_q;
            out_valid_n  = 1'b1;
            skid_valid_n = accept;
            if (accept) skid_n = dec;
        end else if (!out_valid || consume) begin
            out_valid_n = accept;
            if (accept) out_n = dec;
        end else if (accept) begin
            skid_valid_n = 1'b1;
            skid_n       = dec;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q      <= '0;
            skid_q     <= '0;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready_q <= 1'b1;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            out_q      <= out_n;
            skid_q     <= skid_n;
            out_valid  <= out_valid_n;
            skid_valid <= skid_valid_n;
            in_ready_q <= !skid_valid_n;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.ex_valid = out_valid;
    assign bus.alucon   = out_q.alucon;
    assign bus.op1      = out_q.op1;
    assign bus.op2      = out_q.op2;
    assign bus.rd       = out_q.rd;
    assign bus.we       = out_q.we;
`ifdef ID_EX_ILLEGAL_DET_EN
    assign bus.illegal  = out_q.illegal;
`endif

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Scoreboard bench for id_ex_alu_issue: hand-computed expectations queued on accept, compared on EX consume.
// Expectations for malformed encodings follow ID_EX_ILLEGAL_DET_EN.
module tb_id_ex_alu_issue;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  alucon;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } vec_t;

`ifdef ID_EX_ILLEGAL_DET_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    always #5 clk = ~clk;

    id_ex_alu_issue_if bus();

    id_ex_alu_issue dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;
    vec_t        exp_q[$];
    vec_t        tbl[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] instr, pc, rs1, rs2,
                                input logic [3:0] alucon, input logic [31:0] op1, op2,
                                input logic [4:0] rd, input logic we, ill);
        vec_t v;
        v.instr = instr; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
        v.alucon = alucon; v.op1 = op1; v.op2 = op2; v.rd = rd; v.we = we; v.ill = ill;
        return v;
    endfunction

    // Holds in_valid until accepted; pushes the expectation at the negedge before the accepting edge
    task automatic send(input vec_t v, input bit track, output int unsigned waited);
        bit done = 1'b0;
        waited = 0;
        bus.instr = v.instr; bus.pc = v.pc; bus.rs1_data = v.rs1; bus.rs2_data = v.rs2;
        bus.in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) begin
                if (track) exp_q.push_back(v);
                done = 1'b1;
            end else if (++waited > 50) begin
                check("accept_timeout", 32'd0, 32'd1);
                bus.in_valid = 1'b0;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        vec_t e;
        if (rst_n && !flush && bus.ex_valid && bus.ex_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("alucon", 32'(bus.alucon), 32'(e.alucon));
                check("op1", bus.op1, e.op1);
                check("op2", bus.op2, e.op2);
                check("rd", 32'(bus.rd), 32'(e.rd));
                check("we", 32'(bus.we), 32'(e.we));
`ifdef ID_EX_ILLEGAL_DET_EN
                check("illegal", 32'(bus.illegal), 32'(e.ill));
`endif
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned w;
        vec_t xor_bad;

        tbl.push_back(mk(32'h402080B3, 32'h0,   32'd10,        32'd3,  4'd8,  32'd10,        32'd3,          5'd1, 1'b1, 1'b0));
        tbl.push_back(mk(32'h40335293, 32'h0,   32'h80000000,  32'd0,  4'd13, 32'h80000000,  32'd3,          5'd5, 1'b1, 1'b0));
        tbl.push_back(mk(32'h123450B7, 32'h0,   32'h55,        32'h66, 4'd0,  32'd0,         32'h12345000,   5'd1, 1'b1, 1'b0));
        tbl.push_back(mk(32'h0020E463, 32'h0,   32'd1,         32'd2,  4'd3,  32'd1,         32'd2,          5'd0, 1'b0, 1'b0));
        tbl.push_back(mk(32'h010000EF, 32'h100, 32'h9,         32'h9,  4'd0,  32'h100,       32'd4,          5'd1, 1'b1, 1'b0));
        tbl.push_back(mk(32'hFFF00193, 32'h0,   32'd7,         32'd0,  4'd0,  32'd7,         32'hFFFFFFFF,   5'd3, 1'b1, 1'b0));
        tbl.push_back(mk(32'h0020A423, 32'h0,   32'h1000,      32'd5,  4'd0,  32'h1000,      32'd8,          5'd0, 1'b0, 1'b0));
        tbl.push_back(mk(32'h00208033, 32'h0,   32'd1,         32'd2,  4'd0,  32'd1,         32'd2,          5'd0, 1'b0, 1'b0));
        tbl.push_back(mk(32'h0000007F, 32'h40,  32'h11,        32'h22, 4'd0,  32'd0,         32'd0,          5'd0, 1'b0, ILL_EN));
        tbl.push_back(mk(32'h00001217, 32'h200, 32'd0,         32'd0,  4'd0,  32'h200,       32'h1000,       5'd4, 1'b1, 1'b0));
        tbl.push_back(mk(32'h409453B3, 32'h0,   32'hF0000000,  32'd4,  4'd13, 32'hF0000000,  32'd4,          5'd7, 1'b1, 1'b0));
        tbl.push_back(mk(32'hFFC12283, 32'h0,   32'h100,       32'd0,  4'd0,  32'h100,       32'hFFFFFFFC,   5'd5, 1'b1, 1'b0));
        if (ILL_EN)
            xor_bad = mk(32'h4020C0B3, 32'h0, 32'hF0, 32'h0F, 4'd0, 32'd0,  32'd0,  5'd0, 1'b0, 1'b1);
        else
            xor_bad = mk(32'h4020C0B3, 32'h0, 32'hF0, 32'h0F, 4'd4, 32'hF0, 32'h0F, 5'd1, 1'b1, 1'b0);
        tbl.push_back(xor_bad);

        rst_n = 1'b0; flush = 1'b0;
        bus.in_valid = 1'b0; bus.ex_ready = 1'b0;
        bus.instr = '0; bus.pc = '0; bus.rs1_data = '0; bus.rs2_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_alucon",   32'(bus.alucon),   32'd0);
        check("rst_op1",      bus.op1,           32'd0);
        check("rst_op2",      bus.op2,           32'd0);
        check("rst_rd",       32'(bus.rd),       32'd0);
        check("rst_we",       32'(bus.we),       32'd0);
`ifdef ID_EX_ILLEGAL_DET_EN
        check("rst_illegal",  32'(bus.illegal),  32'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single instruction: valid right after the accepting edge
        bus.ex_ready = 1'b1;
        send(tbl[0], 1'b1, w);
        check("latency_valid", 32'(bus.ex_valid), 32'd1);
        check("latency_alucon", 32'(bus.alucon), 32'd8);
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back stream with EX always ready: no stall expected
        foreach (tbl[i]) begin
            send(tbl[i], 1'b1, w);
            check("stream_stall", w, 32'd0);
        end
        repeat (3) @(posedge clk);
        #1;

        // Back-pressure: A in OUT, B in SKID, C held until drain
        bus.ex_ready = 1'b0;
        send(tbl[0], 1'b1, w);
        send(tbl[1], 1'b1, w);
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        fork
            send(tbl[2], 1'b1, w);
            begin
                repeat (2) begin
                    @(negedge clk);
                    check("bp_stall_valid", 32'(bus.ex_valid), 32'd1);
                    check("bp_stall_op1", bus.op1, 32'd10);
                end
                @(posedge clk); #1;
                bus.ex_ready = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check("bp_drain_valid", 32'(bus.ex_valid), 32'd1);
                end
            end
        join
        @(negedge clk);
        check("bp_empty", 32'(bus.ex_valid), 32'd0);
        check("bp_sb_empty", exp_q.size(), 32'd0);
        @(posedge clk); #1;

        // Flush with one or two entries held and an instruction presented
        for (int k = 1; k <= 2; k++) begin
            bus.ex_ready = 1'b0;
            for (int j = 0; j < k; j++) send(tbl[3 + j], 1'b1, w);
            bus.instr = tbl[5].instr; bus.pc = tbl[5].pc;
            bus.rs1_data = tbl[5].rs1; bus.rs2_data = tbl[5].rs2;
            bus.in_valid = 1'b1;
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            bus.in_valid = 1'b0;
            exp_q.delete();
            @(negedge clk);
            check("flush_ex_valid", 32'(bus.ex_valid), 32'd0);
            check("flush_in_ready", 32'(bus.in_ready), 32'd1);
            bus.ex_ready = 1'b1;
            repeat (3) begin
                @(negedge clk);
                check("flush_quiet", 32'(bus.ex_valid), 32'd0);
            end
            @(posedge clk); #1;
        end

        // Reset during a full stall discards both entries
        bus.ex_ready = 1'b0;
        send(tbl[6], 1'b1, w);
        send(tbl[7], 1'b1, w);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("rst_stall_ex_valid", 32'(bus.ex_valid), 32'd0);
        check("rst_stall_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;

        // Post-reset traffic still flows in order
        bus.ex_ready = 1'b1;
        send(tbl[8], 1'b1, w);
        send(tbl[12], 1'b1, w);
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(posedge clk);
        @(negedge clk);
        check("sb_drain", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_alu_issue.md
# id_ex_alu_issue

Decode-to-execute issue stage of the pipelined CPU. Accepts one decoded-stage instruction per cycle with register-file operands and PC. Produces the 4-bit `alucon` code, both ALU operands, and destination-write information for the execute-stage ALU. Registered output with a one-entry skid buffer and valid/ready handshakes on both sides, so back-pressure from EX never forms a combinational path to ID.

## Interface
- No parameters (datapath fixed at RV32I, 32 bits).
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `flush` input 1: synchronous kill of all held and incoming instructions.
- `in_valid` input 1: ID presents an instruction.
- `in_ready` output 1: stage can accept. Registered.
- `instr` input 32: raw RV32I instruction word.
- `pc` input 32: instruction address.
- `rs1_data`, `rs2_data` input 32 each: forwarded register operands.
- `ex_valid` output 1: EX payload valid.
- `ex_ready` input 1: EX accepts the payload.
- `alucon` output 4: ALU op. 0 ADD, 8 SUB, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL, 13 SRA, 6 OR, 7 AND.
- `op1`, `op2` output 32: ALU operands.
- `rd` output 5: destination register.
- `we` output 1: register write enable.
- `illegal` output 1: only present with `ID_EX_ILLEGAL_DET_EN`.

## Operation
Decode uses `opcode=instr[6:0]`, `f3=instr[14:12]`, `f7b5=instr[30]`. Immediates are sign-extended.
- **R-type 0110011:** `alucon={f7b5&(f3==000|f3==101), f3}`; `op1=rs1`, `op2=rs2`; `we=1`.
- **I-ALU 0010011:** `alucon={(f3==101)&f7b5, f3}`; `op2=I-imm`.
  - Shifts (f3 001/101): `op2={27'b0, instr[24:20]}`.
  - `we=1`.
- **Load 0000011:** ADD, `rs1 + I-imm`, `we=1`.
- **Store 0100011:** ADD, `rs1 + S-imm`, `we=0`.
- **LUI 0110111:** ADD, `op1=0`, `op2={instr[31:12],12'b0}`, `we=1`.
- **AUIPC 0010111:** ADD, `op1=pc`, `op2=U-imm`, `we=1`.
- **JAL 1101111 / JALR 1100111:** ADD, `op1=pc`, `op2=4` (link value), `we=1`.
- **Branch 1100011:** `op1=rs1`, `op2=rs2`, `we=0`. f3 000/001 → SUB; 100/101 → SLT; 110/111 → SLTU.
- **Other opcodes:** bubble payload (`alucon=0`, `op1=op2=0`, `rd=0`, `we=0`), still passed with `ex_valid=1`.
- **`rd` output:** `rd=instr[11:7]` whenever `we=1`; otherwise 0. `we` is forced to 0 when `rd==0`.

Buffering: output register (OUT) plus skid register (SKID).
- **Accept:** an instruction is accepted when `in_valid & in_ready`.
- **Routing on accept:**
  - OUT empty, or OUT being consumed (`ex_valid & ex_ready`) with SKID empty → decoded payload loads OUT.
  - Otherwise → decoded payload loads SKID.
- **Drain:** when OUT is consumed and SKID is full, SKID moves to OUT. If an accept happens in the same cycle, it loads SKID.
- **`in_ready`:** next value is `!skid_full_next`.
- **Flush:** has priority over everything. OUT and SKID valid are cleared, and the input accepted that cycle is discarded. `in_ready=1` the next cycle.
- **Reset:** `ex_valid=0`, `in_ready=1`, `alucon=0`, `op1=op2=0`, `rd=0`, `we=0`, `illegal=0`. SKID is empty.
- **Ordering:** instructions leave in acceptance order; none is dropped or duplicated.

## Timing
- **Latency:** accept at edge N → `ex_valid` and payload visible after edge N, consumable at edge N+1.
- **Throughput:** one instruction per cycle while `ex_ready=1`.
- **Stall:** with `ex_ready=0`, one more instruction is absorbed into SKID. `in_ready` falls after that edge.
- **Stability:** payload holds stable while `ex_valid & !ex_ready`.
- **Combinational paths:** none from `ex_ready` to `in_ready`.
- **Reset mid-stall:** discards both entries in the same cycle as the reset edge.

## Configuration
- **`ID_EX_ILLEGAL_DET_EN` defined:**
  - Adds the `illegal` output, registered alongside the payload.
  - `illegal=1` for: unknown opcodes; R-type with `instr[31:25]` ∉ {0000000, 0100000}; R-type 0100000 with f3 ∉ {000, 101}; I-shift with `instr[31:25]` illegal for its f3; branch f3 010/011.
  - Payload for an illegal instruction is the bubble.
- **Undefined:** no port. Unknown opcodes produce the bubble. Malformed funct7 decodes from `f7b5` alone.

## Test plan
- Reset, then `sub x1,x1,x2` (0x402080B3) with rs1=10, rs2=3 → next cycle `ex_valid=1`, `alucon=8`, `op1=10`, `op2=3`, `rd=1`, `we=1`.
- `srai x5,x6,3` (0x40335293) with rs1=0x80000000 → `alucon=13`, `op2=3`, `rd=5`. Then `lui x1,0x12345` (0x123450B7) → `alucon=0`, `op1=0`, `op2=0x12345000`.
- `bltu` (f3=110) with rs1=1, rs2=2 → `alucon=3`, `we=0`, `rd=0`. `jal` at pc=0x100 → `op1=0x100`, `op2=4`.
- Back-pressure: stream 3 instructions with `ex_ready=0` → first in OUT, second in SKID, `in_ready=0`. Raise `ex_ready` → three instructions emerge in order on consecutive cycles, none lost.
- Flush with OUT and SKID full and `in_valid=1` → next cycle `ex_valid=0`, `in_ready=1`; none of the three instructions appears.
- Macro on: opcode 0x7F → `illegal=1`, bubble payload. Macro off: same input → bubble, no `illegal` port.
